// File: rtl/ball_pair_collision.sv
// Ball-pair collision detector: once per frame checks overlap and approach of two
// balls through a short pipeline and, on a hit, pulses both balls with swapped velocities.
module ball_pair_collision #(
   parameter int unsigned BALL_SIZE       = 16,
   parameter int unsigned COOLDOWN_FRAMES = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               ballA_active,
   input  logic               ballB_active,
   input  logic [10:0]        ballA_topLeftX,
   input  logic [10:0]        ballA_topLeftY,
   input  logic [10:0]        ballB_topLeftX,
   input  logic [10:0]        ballB_topLeftY,
   input  logic signed [31:0] ballA_velX,
   input  logic signed [31:0] ballA_velY,
   input  logic signed [31:0] ballB_velX,
   input  logic signed [31:0] ballB_velY,
   output logic               collisionA,
   output logic               collisionB,
   output logic signed [31:0] newVelAX,
   output logic signed [31:0] newVelAY,
   output logic signed [31:0] newVelBX,
   output logic signed [31:0] newVelBY,
   output logic               engaged
);

   localparam int unsigned BALL_SQ = BALL_SIZE * BALL_SIZE;
   localparam int unsigned CNT_W   = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   typedef enum logic [2:0] {IDLE, SAMPLE, DIFF, CMP, FIRE, COOLDOWN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               engaged_q, engaged_d;
   logic               fire_d, collision_q;

   logic               act_a_q, act_b_q;
   logic [10:0]        ax_q, ay_q, bx_q, by_q;
   logic signed [31:0] vax_q, vay_q, vbx_q, vby_q;
   logic signed [11:0] dx_q, dy_q;
   logic signed [31:0] dvx_q, dvy_q;
   logic signed [31:0] nvax_q, nvay_q, nvbx_q, nvby_q;

   // CMP-stage arithmetic; sign-extended operands keep products exact
   logic signed [23:0] dx24, dy24;
   logic signed [23:0] dx_sq, dy_sq;
   logic [23:0]        dist2;
   logic signed [47:0] dx48, dy48, dvx48, dvy48, dot;
   logic               near, both_act, hit;

   assign dx24     = {{12{dx_q[11]}}, dx_q};
   assign dy24     = {{12{dy_q[11]}}, dy_q};
   assign dx_sq    = dx24 * dx24;
   assign dy_sq    = dy24 * dy24;
   assign dist2    = $unsigned(dx_sq) + $unsigned(dy_sq);
   assign dx48     = {{36{dx_q[11]}}, dx_q};
   assign dy48     = {{36{dy_q[11]}}, dy_q};
   assign dvx48    = {{16{dvx_q[31]}}, dvx_q};
   assign dvy48    = {{16{dvy_q[31]}}, dvy_q};
   assign dot      = (dx48 * dvx48) + (dy48 * dvy48);
   assign near     = (32'(dist2) < BALL_SQ);
   assign both_act = act_a_q & act_b_q;
   assign hit      = both_act & near & dot[47] & ~engaged_q;

   // State register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         engaged_q   <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         engaged_q   <= engaged_d;
         collision_q <= fire_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      engaged_d = engaged_q;
      fire_d    = 1'b0;
      case (state_q)
         IDLE:     if (startOfFrame) state_d = SAMPLE;
         SAMPLE:   state_d = DIFF;
         DIFF:     state_d = CMP;
         CMP: begin
            if (hit) begin
               state_d   = FIRE;
               fire_d    = 1'b1;
               engaged_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
            if (!near || !both_act) engaged_d = 1'b0;
         end
         FIRE: begin
            state_d = COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_FRAMES);
         end
         COOLDOWN: begin
            if (startOfFrame) begin
               if (cnt_q == '0) state_d = SAMPLE;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default:  state_d = IDLE;
      endcase
   end

   // Sample, difference and result registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         act_a_q <= 1'b0;  act_b_q <= 1'b0;
         ax_q    <= '0;    ay_q    <= '0;
         bx_q    <= '0;    by_q    <= '0;
         vax_q   <= '0;    vay_q   <= '0;
         vbx_q   <= '0;    vby_q   <= '0;
         dx_q    <= '0;    dy_q    <= '0;
         dvx_q   <= '0;    dvy_q   <= '0;
         nvax_q  <= '0;    nvay_q  <= '0;
         nvbx_q  <= '0;    nvby_q  <= '0;
      end else begin
         if (state_q == SAMPLE) begin
            act_a_q <= ballA_active;    act_b_q <= ballB_active;
            ax_q    <= ballA_topLeftX;  ay_q    <= ballA_topLeftY;
            bx_q    <= ballB_topLeftX;  by_q    <= ballB_topLeftY;
            vax_q   <= ballA_velX;      vay_q   <= ballA_velY;
            vbx_q   <= ballB_velX;      vby_q   <= ballB_velY;
         end
         if (state_q == DIFF) begin
            dx_q  <= $signed({1'b0, bx_q}) - $signed({1'b0, ax_q});
            dy_q  <= $signed({1'b0, by_q}) - $signed({1'b0, ay_q});
            dvx_q <= vbx_q - vax_q;
            dvy_q <= vby_q - vay_q;
         end
         // Equal-mass elastic hit: velocities simply swap
         if (fire_d) begin
            nvax_q <= vbx_q;  nvay_q <= vby_q;
            nvbx_q <= vax_q;  nvby_q <= vay_q;
         end
      end
   end

   assign collisionA = collision_q;
   assign collisionB = collision_q;
   assign newVelAX   = nvax_q;
   assign newVelAY   = nvay_q;
   assign newVelBX   = nvbx_q;
   assign newVelBY   = nvby_q;
   assign engaged    = engaged_q;

endmodule

// File: tb/tb_ball_pair_collision.sv
// Directed bench for ball_pair_collision: hits, misses, lockout/cooldown and reset abort.
`timescale 1ns/1ps
module tb_ball_pair_collision;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               ballA_active, ballB_active;
   logic [10:0]        ballA_topLeftX, ballA_topLeftY, ballB_topLeftX, ballB_topLeftY;
   logic signed [31:0] ballA_velX, ballA_velY, ballB_velX, ballB_velY;
   logic               collisionA, collisionB;
   logic signed [31:0] newVelAX, newVelAY, newVelBX, newVelBY;
   logic               engaged;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ball_pair_collision #(.BALL_SIZE(16), .COOLDOWN_FRAMES(4)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .ballA_active(ballA_active), .ballB_active(ballB_active),
      .ballA_topLeftX(ballA_topLeftX), .ballA_topLeftY(ballA_topLeftY),
      .ballB_topLeftX(ballB_topLeftX), .ballB_topLeftY(ballB_topLeftY),
      .ballA_velX(ballA_velX), .ballA_velY(ballA_velY),
      .ballB_velX(ballB_velX), .ballB_velY(ballB_velY),
      .collisionA(collisionA), .collisionB(collisionB),
      .newVelAX(newVelAX), .newVelAY(newVelAY),
      .newVelBX(newVelBX), .newVelBY(newVelBY),
      .engaged(engaged)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(want));
      end
   endtask

   task automatic set_balls(input int ax, input int ay, input int avx, input int avy,
                            input int bx, input int by, input int bvx, input int bvy,
                            input bit aact, input bit bact);
      ballA_topLeftX = 11'(ax);  ballA_topLeftY = 11'(ay);
      ballB_topLeftX = 11'(bx);  ballB_topLeftY = 11'(by);
      ballA_velX = 32'(avx);     ballA_velY = 32'(avy);
      ballB_velX = 32'(bvx);     ballB_velY = 32'(bvy);
      ballA_active = aact;       ballB_active = bact;
   endtask

   task automatic check_outputs(input string tag, input int ax, input int ay,
                                input int bx, input int by, input bit eng);
      check({tag, "_vAX"}, 64'(newVelAX), 64'(ax));
      check({tag, "_vAY"}, 64'(newVelAY), 64'(ay));
      check({tag, "_vBX"}, 64'(newVelBX), 64'(bx));
      check({tag, "_vBY"}, 64'(newVelBY), 64'(by));
      check({tag, "_engaged"}, 64'(engaged), 64'(eng));
   endtask

   // One frame: pulse startOfFrame, then watch cycles +1..+8 for the hit pulse
   task automatic run_frame(input string tag, input bit exp_hit);
      int pa = 0, pb = 0, pos = 0;
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (collisionA) begin pa++; pos = k; end
         if (collisionB) pb++;
         @(negedge clk);
      end
      check({tag, "_pulsesA"}, 64'(pa), exp_hit ? 64'd1 : 64'd0);
      check({tag, "_pulsesB"}, 64'(pb), exp_hit ? 64'd1 : 64'd0);
      if (exp_hit) check({tag, "_latency"}, 64'(pos), 64'd4);
   endtask

   task automatic apply_reset();
      @(negedge clk) resetN = 1'b0;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int pulses;
      resetN = 1'b0;
      startOfFrame = 1'b0;
      set_balls(100, 100, 64, 0, 110, 100, 0, 0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      check("rst_colA", 64'(collisionA), 64'd0);
      check_outputs("rst", 0, 0, 0, 0, 1'b0);
      resetN = 1'b1;
      repeat (2) @(negedge clk);

      // Basic approaching hit: velocities swap, pair locks out
      run_frame("hit", 1'b1);
      check_outputs("hit", 0, 0, 64, 0, 1'b1);

      // Held overlap through cooldown and beyond: no second pulse
      for (int f = 0; f < 10; f++) run_frame("hold", 1'b0);
      check_outputs("hold", 0, 0, 64, 0, 1'b1);

      // Separate for one frame, then come back approaching
      set_balls(100, 100, 64, 0, 130, 100, 0, 0, 1'b1, 1'b1);
      run_frame("apart", 1'b0);
      check("apart_engaged", 64'(engaged), 64'd0);
      set_balls(100, 100, 64, 0, 110, 100, 0, 0, 1'b1, 1'b1);
      run_frame("rehit", 1'b1);
      check("rehit_engaged", 64'(engaged), 64'd1);

      // Drain cooldown with the balls apart so engaged clears
      set_balls(100, 100, 64, 0, 130, 100, 0, 0, 1'b1, 1'b1);
      for (int f = 0; f < 5; f++) run_frame("drain", 1'b0);
      check_outputs("drain", 0, 0, 64, 0, 1'b0);

      // Reset asserted during DIFF of a hitting frame
      set_balls(100, 100, 64, 0, 110, 100, 0, 0, 1'b1, 1'b1);
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      @(negedge clk) resetN = 1'b0;
      #1;
      check("rstdiff_colA", 64'(collisionA), 64'd0);
      check_outputs("rstdiff", 0, 0, 0, 0, 1'b0);
      @(negedge clk) resetN = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (collisionA || collisionB) pulses++;
         @(negedge clk);
      end
      check("rstdiff_nopulse", 64'(pulses), 64'd0);
      run_frame("posthit", 1'b1);
      check_outputs("posthit", 0, 0, 64, 0, 1'b1);

      // Too far apart: dist2 = 400
      apply_reset();
      set_balls(100, 100, 64, 0, 120, 100, 0, 0, 1'b1, 1'b1);
      run_frame("far", 1'b0);
      check_outputs("far", 0, 0, 0, 0, 1'b0);

      // Overlapping but receding: dot = +640
      set_balls(100, 100, -64, 0, 110, 100, 0, 0, 1'b1, 1'b1);
      run_frame("recede", 1'b0);
      check("recede_engaged", 64'(engaged), 64'd0);

      // Ball B pocketed
      set_balls(100, 100, 64, 0, 110, 100, 0, 0, 1'b1, 1'b0);
      run_frame("inactive", 1'b0);
      check("inactive_engaged", 64'(engaged), 64'd0);

      // Boundary: dist2 = 256 is not contact, 225 is
      set_balls(100, 100, 64, 0, 116, 100, 0, 0, 1'b1, 1'b1);
      run_frame("edge16", 1'b0);
      set_balls(100, 100, 64, 0, 115, 100, 0, 0, 1'b1, 1'b1);
      run_frame("edge15", 1'b1);
      check_outputs("edge15", 0, 0, 64, 0, 1'b1);

      // Vertical hit with B above A: dy = -10, dvy = +100, dot = -1000
      apply_reset();
      set_balls(200, 300, 0, 0, 200, 290, 0, 100, 1'b1, 1'b1);
      run_frame("vert", 1'b1);
      check_outputs("vert", 0, 100, 0, 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
